axi_wr_arbiter: RTL
===================

# axi_wr_arbiter

Two-channel write scheduler that shares one AXI write address/data path into the DDR controller between two burst sources, such as a record stream and a processed-audio stream. Each channel owns a circular address region in DDR. The block grants bursts round-robin, issues the address handshake, steers write data from the granted channel, and advances and wraps that channel's write pointer. It sits between the channel FIFOs and the DDR controller's AXI write port, in the DDR core clock domain.

## Interface
- CTRL_ADDR_WIDTH, 28: AXI address width.
- DQ_WIDTH, 32: DDR DQ width; the data bus is DQ_WIDTH*8 bits.
- BURST_LEN, 16: beats per burst; ADDR_STEP = BURST_LEN*8.
- CH0_BASE, 0: channel 0 region base address.
- CH1_BASE, 'h0080_0000: channel 1 region base address.
- REGION_SIZE, 'h0080_0000: region length per channel; must be a multiple of ADDR_STEP.
- WDT_CYCLES, 1024: watchdog limit (only used when the watchdog is compiled in).

Ports:
- clk  in  1  DDR core clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- ch0_rready, ch1_rready  in  1  channel holds at least one burst; asynchronous to clk, synchronized internally.
- ch0_enable, ch1_enable  in  1  channel allowed to request.
- ch0_addr_clr, ch1_addr_clr  in  1  one-cycle pulse; rewinds the channel pointer to its base.
- ch0_data, ch1_data  in  DQ_WIDTH*8  channel write data.
- ch0_rd_en, ch1_rd_en  out  1  channel data pop.
- axi_awaddr  out  CTRL_ADDR_WIDTH  registered burst address.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address ready.
- axi_wdata  out  DQ_WIDTH*8  muxed write data.
- axi_wready  in  1  controller accepts a beat.
- axi_wlast  in  1  controller-driven last-beat flag.
- grant  out  1  channel owning the current or last burst.
- ch0_wrap, ch1_wrap  out  1  one-cycle pulse when a pointer wraps.
- wdt_err  out  1  one-cycle pulse on a watchdog abort.

## Operation
- **Request synchronization:** each chN_rready passes through a 2-flop synchronizer. reqN = sync2 & chN_enable.
- **IDLE:**
  - If no req: stay in IDLE.
  - If exactly one req: grant that channel.
  - If both req: grant the channel that is not last_grant. last_grant resets to 1, so ch0 wins the first tie.
  - On grant: go to AWADDR. At the same edge, load axi_awaddr with the granted channel's pointer, set axi_awvalid=1, and update grant and last_grant.
- **AWADDR:**
  - Hold axi_awaddr and axi_awvalid until axi_awvalid & axi_awready.
  - At the handshake edge: axi_awvalid=0, the granted pointer advances, state goes to WDATA.
- **WDATA:**
  - axi_wdata = data of the granted channel.
  - chN_rd_en = axi_wready & (state==WDATA) & (grant==N), combinational. The non-granted rd_en is always 0.
  - Go to IDLE on the edge where axi_wlast=1.
- **Pointer advance:** next = ptr + ADDR_STEP, computed in CTRL_ADDR_WIDTH+1 bits.
  - If next >= base+REGION_SIZE: ptr = base and chN_wrap pulses for one cycle.
  - Otherwise ptr = next.
- **Pointer clear:** chN_addr_clr sets ptr = base.
  - If clear and advance coincide on the same channel, clear wins and no wrap pulse is issued.
  - A clear during AWADDR or WDATA does not alter the address already presented; it takes effect for the next burst.
- **Enable deassert mid-burst:** the current burst completes. The channel is not granted again while disabled.

## Timing
- **Reset values:** state=IDLE, axi_awaddr=0, axi_awvalid=0, grant=0, last_grant=1, both pointers at their bases, wrap=0, wdt_err=0, synchronizers=0. rd_en is 0 because it is gated by state.
- **Reset mid-burst:** all of the above apply immediately (asynchronous). The partial burst is abandoned.
- **Latency:** with ch0_rready rising before edge 1, axi_awvalid is high after edge 3.
- **Minimum spacing:** the earliest next grant is the edge after wlast, so there is one IDLE cycle between bursts.
- **Address channel:** axi_awvalid never drops without a handshake, and axi_awaddr is stable while valid.
- **Data phase:** no rd_en outside WDATA. axi_wdata is don't-care outside WDATA.

## Configuration
- **AXI_WR_ARB_WATCHDOG_EN defined:**
  - A counter clears on entry to WDATA and increments each WDATA cycle.
  - When it reaches WDT_CYCLES without axi_wlast: return to IDLE, pulse wdt_err, and leave the pointer advanced.
- **Not defined:** no counter exists, WDATA waits indefinitely, and wdt_err is tied to 0.

## Test plan
- **Single channel:** ch0 only, awready=1, wready=1, wlast on beat 16 → awaddr 0, then 'h80, then 'h100. ch0_rd_en is high 16 cycles per burst. ch1_rd_en stays 0.
- **Tie arbitration:** both ready continuously → grants go 0,1,0,1. awaddr sequence is 0, 'h80_0000, 'h80, 'h80_0080.
- **Wrap:** REGION_SIZE='h100 with ch0 only → addresses 0, 'h80, 0. ch0_wrap pulses once, at the second handshake.
- **Clear vs. advance:** ch1_addr_clr pulses on the same edge as ch1's aw handshake → the next ch1 burst uses 'h80_0000 and no wrap pulse is issued.
- **Backpressure and reset:** awready held low 5 cycles → awvalid and awaddr stay stable throughout. Asserting rst low during WDATA → awvalid=0, rd_en=0, and state returns to IDLE with no clk edge.
- **Watchdog (macro on):** WDT_CYCLES=32, wlast never asserted → wdt_err pulses 32 cycles after WDATA entry and the next grant follows.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//
// Shares one AXI write address/data path between two burst sources. Each
// channel owns a circular DDR region. Bursts are granted round-robin. For
// each burst the block issues the address handshake and steers write data
// from the granted channel. It then advances that channel's write pointer,
// wrapping it at the end of the region.
//
// Optional feature: define AXI_WR_ARB_WATCHDOG_EN to abort a data phase
// that sees no axi_wlast within WDT_CYCLES cycles. When it is undefined,
// wdt_err is tied low.
//
// Ports
//   clk, rst                 DDR core clock; asynchronous active-low reset
//   chN_rready               channel holds a burst (asynchronous, synchronized here)
//   chN_enable               channel allowed to request
//   chN_addr_clr             one-cycle pulse, rewinds the channel pointer to its base
//   chN_data                 channel write data
//   chN_rd_en                channel data pop (combinational)
//   axi_awaddr/awvalid/awready  AXI write address channel
//   axi_wdata/wready/wlast   AXI write data channel (wlast driven by the controller)
//   grant                    channel owning the current or last burst
//   chN_wrap                 one-cycle pulse when a pointer wraps
//   wdt_err                  one-cycle pulse on a watchdog abort
module axi_wr_arbiter #(
  parameter int unsigned                  CTRL_ADDR_WIDTH = 28,
  parameter int unsigned                  DQ_WIDTH        = 32,
  parameter int unsigned                  BURST_LEN       = 16,
  parameter logic [CTRL_ADDR_WIDTH-1:0]   CH0_BASE        = '0,
  parameter logic [CTRL_ADDR_WIDTH-1:0]   CH1_BASE        = 'h0080_0000,
  parameter int unsigned                  REGION_SIZE     = 'h0080_0000,
  parameter int unsigned                  WDT_CYCLES      = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ch0_rready,
  input  logic                       ch1_rready,
  input  logic                       ch0_enable,
  input  logic                       ch1_enable,
  input  logic                       ch0_addr_clr,
  input  logic                       ch1_addr_clr,
  input  logic [DQ_WIDTH*8-1:0]      ch0_data,
  input  logic [DQ_WIDTH*8-1:0]      ch1_data,
  output logic                       ch0_rd_en,
  output logic                       ch1_rd_en,
  output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [DQ_WIDTH*8-1:0]      axi_wdata,
  input  logic                       axi_wready,
  input  logic                       axi_wlast,
  output logic                       grant,
  output logic                       ch0_wrap,
  output logic                       ch1_wrap,
  output logic                       wdt_err
);

  localparam int unsigned AddrStep = BURST_LEN * 8;
  localparam int unsigned PtrWidth = CTRL_ADDR_WIDTH + 1;

  // Pointer arithmetic uses one extra bit so the end-of-region compare
  // cannot be fooled by overflow at the top of the address space.
  localparam logic [PtrWidth-1:0] StepExt = PtrWidth'(AddrStep);
  localparam logic [PtrWidth-1:0] Ch0End  = {1'b0, CH0_BASE} + PtrWidth'(REGION_SIZE);
  localparam logic [PtrWidth-1:0] Ch1End  = {1'b0, CH1_BASE} + PtrWidth'(REGION_SIZE);

  typedef enum logic [1:0] {StIdle, StAwaddr, StWdata} state_e;

  state_e                     state_q, state_d;
  logic                       ch0_meta_q, ch0_sync_q, ch1_meta_q, ch1_sync_q;
  logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                       awvalid_q, awvalid_d;
  logic                       grant_q, grant_d;
  logic                       last_grant_q, last_grant_d;
  logic [CTRL_ADDR_WIDTH-1:0] ptr0_q, ptr0_d, ptr1_q, ptr1_d;
  logic                       wrap0_q, wrap0_d, wrap1_q, wrap1_d;
  logic [PtrWidth-1:0]        ch0_next, ch1_next;
  logic                       req0, req1;
  logic                       adv0, adv1;

`ifdef AXI_WR_ARB_WATCHDOG_EN
  localparam int unsigned        WdtWidth = $clog2(WDT_CYCLES + 1);
  localparam logic [WdtWidth-1:0] WdtLast = WdtWidth'(WDT_CYCLES - 1);

  logic [WdtWidth-1:0] wdt_cnt_q, wdt_cnt_d;
  logic                wdt_err_q, wdt_err_d;
`endif

  assign req0 = ch0_sync_q & ch0_enable;
  assign req1 = ch1_sync_q & ch1_enable;

  // Arbitration, address handshake and data-phase sequencing.
  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    adv0         = 1'b0;
    adv1         = 1'b0;
`ifdef AXI_WR_ARB_WATCHDOG_EN
    wdt_cnt_d    = wdt_cnt_q;
    wdt_err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          // On a tie the channel that did not win last time goes first.
          grant_d      = (req0 & req1) ? ~last_grant_q : req1;
          last_grant_d = grant_d;
          awaddr_d     = grant_d ? ptr1_q : ptr0_q;
          awvalid_d    = 1'b1;
          state_d      = StAwaddr;
        end
      end
      StAwaddr: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = StWdata;
          adv0      = ~grant_q;
          adv1      = grant_q;
`ifdef AXI_WR_ARB_WATCHDOG_EN
          wdt_cnt_d = '0;
`endif
        end
      end
      StWdata: begin
        if (axi_wlast) begin
          state_d = StIdle;
        end
`ifdef AXI_WR_ARB_WATCHDOG_EN
        // The pointer was already advanced at the handshake and stays so.
        else if (wdt_cnt_q == WdtLast) begin
          state_d   = StIdle;
          wdt_err_d = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + WdtWidth'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointer advance/wrap. A clear overrides a coincident advance and
  // suppresses its wrap pulse.
  always_comb begin
    ch0_next = {1'b0, ptr0_q} + StepExt;
    ch1_next = {1'b0, ptr1_q} + StepExt;
    ptr0_d   = ptr0_q;
    ptr1_d   = ptr1_q;
    wrap0_d  = 1'b0;
    wrap1_d  = 1'b0;
    if (adv0) begin
      if (ch0_next >= Ch0End) begin
        ptr0_d  = CH0_BASE;
        wrap0_d = 1'b1;
      end else begin
        ptr0_d = ch0_next[CTRL_ADDR_WIDTH-1:0];
      end
    end
    if (adv1) begin
      if (ch1_next >= Ch1End) begin
        ptr1_d  = CH1_BASE;
        wrap1_d = 1'b1;
      end else begin
        ptr1_d = ch1_next[CTRL_ADDR_WIDTH-1:0];
      end
    end
    if (ch0_addr_clr) begin
      ptr0_d  = CH0_BASE;
      wrap0_d = 1'b0;
    end
    if (ch1_addr_clr) begin
      ptr1_d  = CH1_BASE;
      wrap1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      ch0_meta_q   <= 1'b0;
      ch0_sync_q   <= 1'b0;
      ch1_meta_q   <= 1'b0;
      ch1_sync_q   <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ptr0_q       <= CH0_BASE;
      ptr1_q       <= CH1_BASE;
      wrap0_q      <= 1'b0;
      wrap1_q      <= 1'b0;
`ifdef AXI_WR_ARB_WATCHDOG_EN
      wdt_cnt_q    <= '0;
      wdt_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ch0_meta_q   <= ch0_rready;
      ch0_sync_q   <= ch0_meta_q;
      ch1_meta_q   <= ch1_rready;
      ch1_sync_q   <= ch1_meta_q;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ptr0_q       <= ptr0_d;
      ptr1_q       <= ptr1_d;
      wrap0_q      <= wrap0_d;
      wrap1_q      <= wrap1_d;
`ifdef AXI_WR_ARB_WATCHDOG_EN
      wdt_cnt_q    <= wdt_cnt_d;
      wdt_err_q    <= wdt_err_d;
`endif
    end
  end

  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign grant       = grant_q;
  assign ch0_wrap    = wrap0_q;
  assign ch1_wrap    = wrap1_q;
  assign axi_wdata   = grant_q ? ch1_data : ch0_data;
  assign ch0_rd_en   = axi_wready & (state_q == StWdata) & ~grant_q;
  assign ch1_rd_en   = axi_wready & (state_q == StWdata) & grant_q;

`ifdef AXI_WR_ARB_WATCHDOG_EN
  assign wdt_err = wdt_err_q;
`else
  assign wdt_err = 1'b0;
`endif

endmodule
